// File: rtl/mux8_rr_tx_pkg.sv
// Shared types and helpers for the 8:1 round-robin select/data transmitter.
package mux8_rr_tx_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Round-robin pointer advance; the 3-bit add wraps 7 -> 0 naturally.
  function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
    return p + 3'd1;
  endfunction

  // Even parity over a zero-extended word.
  function automatic logic even_par(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/mux8_rr_tx_rr_arbiter8.sv
// Combinational 8-way round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter8
  import mux8_rr_tx_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NCH-1:0]   gnt_oh,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    logic [SEL_W-1:0] idx_v;
    idx_v   = 3'd0;
    gnt_idx = 3'd0;
    any     = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx_v = ptr + SEL_W'(i);
      if (req[idx_v]) begin
        gnt_idx = idx_v;
        any     = 1'b1;
      end else begin
        gnt_idx = gnt_idx;
        any     = any;
      end
    end
  end

  // One-hot form of the winning index.
  always_comb begin
    gnt_oh = 8'b0000_0000;
    if (any) begin
      gnt_oh[gnt_idx] = 1'b1;
    end else begin
      gnt_oh = 8'b0000_0000;
    end
  end

endmodule

// File: rtl/mux8_rr_tx.sv
// Transmit side of the 1:8 select/data link: round-robin merge of 8 channels onto sel/a_out.
// Optional even-parity output a_par is enabled by defining MUX8_RR_TX_PARITY_EN.
module mux8_rr_tx
  import mux8_rr_tx_pkg::*;
#(
  parameter int DW    = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NCH-1:0]     ch_valid,
  input  logic [NCH*DW-1:0]  ch_data,
  output logic [NCH-1:0]     ch_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [DW-1:0]      a_out,
  output logic               a_valid,
  input  logic               a_ready,
  output logic [CNT_W-1:0]   sent_cnt
`ifdef MUX8_RR_TX_PARITY_EN
  ,
  output logic               a_par
`endif
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] sel_r;
  logic [DW-1:0]    a_out_r;
  logic             a_valid_r;
  logic [CNT_W-1:0] sent_cnt_r;

  logic [NCH-1:0]   gnt_oh_s;
  logic [SEL_W-1:0] gnt_idx_s;
  logic             any_s;
  logic             load_ok_s;
  logic             grant_s;
  logic [DW-1:0]    gnt_data_s;

  rr_arbiter8 u_arb (
    .req     (ch_valid),
    .ptr     (ptr_r),
    .gnt_oh  (gnt_oh_s),
    .gnt_idx (gnt_idx_s),
    .any     (any_s)
  );

  assign gnt_data_s = ch_data[int'(gnt_idx_s) * DW +: DW];

  // Load permission, grant decision and next state.
  always_comb begin
    load_ok_s   = 1'b0;
    grant_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    load_ok_s = 1'b1;
      SEND:    load_ok_s = a_ready;
      default: load_ok_s = 1'b0;
    endcase
    grant_s = load_ok_s & en & any_s;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (a_ready && !grant_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant strobe; rst_n gating makes it fall the instant reset asserts.
  always_comb begin
    ch_ready = 8'b0000_0000;
    if (rst_n && grant_s) begin
      ch_ready = gnt_oh_s;
    end else begin
      ch_ready = 8'b0000_0000;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output word stage and round-robin pointer; a_out is cleared when the word leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r     <= 3'd0;
      a_out_r   <= '0;
      a_valid_r <= 1'b0;
      ptr_r     <= 3'd0;
    end else if (grant_s) begin
      sel_r     <= gnt_idx_s;
      a_out_r   <= gnt_data_s;
      a_valid_r <= 1'b1;
      ptr_r     <= ptr_inc(gnt_idx_s);
    end else if (a_valid_r && a_ready) begin
      a_out_r   <= '0;
      a_valid_r <= 1'b0;
    end
  end

  // Saturating count of completed output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt_r <= '0;
    end else if (a_valid_r && a_ready && !(&sent_cnt_r)) begin
      sent_cnt_r <= sent_cnt_r + CNT_W'(1);
    end
  end

`ifdef MUX8_RR_TX_PARITY_EN
  logic a_par_r;

  // Parity travels with the data word and clears with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_par_r <= 1'b0;
    end else if (grant_s) begin
      a_par_r <= even_par(32'(gnt_data_s));
    end else if (a_valid_r && a_ready) begin
      a_par_r <= 1'b0;
    end
  end

  assign a_par = a_par_r;
`endif

  assign sel      = sel_r;
  assign a_out    = a_out_r;
  assign a_valid  = a_valid_r;
  assign sent_cnt = sent_cnt_r;

endmodule

// File: tb/tb_mux8_rr_tx.sv
// Directed + random bench for mux8_rr_tx with a reference model and expected-word queue.
module tb_mux8_rr_tx;

  localparam int DW    = 1;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [7:0]        ch_valid;
  logic [8*DW-1:0]   ch_data;
  logic [7:0]        ch_ready;
  logic [2:0]        sel;
  logic [DW-1:0]     a_out;
  logic              a_valid;
  logic              a_ready;
  logic [CNT_W-1:0]  sent_cnt;
`ifdef MUX8_RR_TX_PARITY_EN
  logic              a_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [2+DW:0] sb_q[$];
  int            m_ptr;
  bit            m_valid;
  int            m_cnt;

  mux8_rr_tx #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .sel      (sel),
    .a_out    (a_out),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .sent_cnt (sent_cnt)
`ifdef MUX8_RR_TX_PARITY_EN
    ,
    .a_par    (a_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check comb/registered outputs at negedge against the model, then advance.
  task automatic tick();
    bit            lo;
    bit            gr;
    int            g;
    logic [31:0]   exp_rdy;
    logic [2+DW:0] item;
    @(negedge clk);
    lo = !m_valid || a_ready;
    g  = -1;
    for (int k = 0; k < 8; k++) begin
      if (g < 0 && ch_valid[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
    end
    gr = lo && en && (g >= 0);
    exp_rdy = gr ? (32'd1 << g) : 32'd0;
    chk("ch_ready", 32'(ch_ready), exp_rdy);
    chk("a_valid", 32'(a_valid), 32'(m_valid));
    if (m_valid && sb_q.size() > 0) begin
      item = sb_q[0];
      chk("sel", 32'(sel), 32'(item[2+DW:DW]));
      chk("a_out", 32'(a_out), 32'(item[DW-1:0]));
`ifdef MUX8_RR_TX_PARITY_EN
      chk("a_par", 32'(a_par), 32'(^item[DW-1:0]));
`endif
      if (a_ready) begin
        void'(sb_q.pop_front());
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end else begin
      chk("a_out_idle", 32'(a_out), 32'd0);
    end
    if (gr) begin
      sb_q.push_back({3'(g), ch_data[g*DW +: DW]});
      m_ptr = (g + 1) % 8;
    end
    m_valid = gr || (m_valid && !a_ready);
    @(posedge clk);
    #1;
    chk("sent_cnt", 32'(sent_cnt), 32'(m_cnt));
  endtask

  initial begin
    m_ptr   = 0;
    m_valid = 1'b0;
    m_cnt   = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    a_ready  = 1'b1;
    ch_valid = 8'hFF;
    ch_data  = 8'h00;
    #3;
    chk("rst_ch_ready", 32'(ch_ready), 32'd0);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full round robin: sel walks 0..7 and wraps to 0.
    ch_data = 8'b1010_0101;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_sel", 32'(sel), 32'(i % 8));
    end
    chk("rr_cnt8", 32'(sent_cnt), 32'd8);

    // Sparse: reach ptr=3 via ch2, then scan wraps 7 before 2.
    ch_valid = 8'h04;
    tick();
    chk("sp_sel2", 32'(sel), 32'd2);
    ch_valid = 8'b1000_0100;
    tick();
    chk("sp_sel7", 32'(sel), 32'd7);
    tick();
    chk("sp_sel2b", 32'(sel), 32'd2);

    // Stall with sel=5, a_out=1.
    ch_valid = 8'h20;
    ch_data  = 8'h20;
    tick();
    chk("st_sel", 32'(sel), 32'd5);
    chk("st_a_out", 32'(a_out), 32'd1);
    a_ready  = 1'b0;
    ch_valid = 8'hFF;
    ch_data  = 8'hDF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_hold_sel", 32'(sel), 32'd5);
      chk("st_hold_a_out", 32'(a_out), 32'd1);
      chk("st_hold_valid", 32'(a_valid), 32'd1);
    end
    a_ready = 1'b1;
    ch_data = 8'h40;
    tick();
    chk("st_nobubble_valid", 32'(a_valid), 32'd1);
    chk("st_nobubble_sel", 32'(sel), 32'd6);
    chk("st_nobubble_a_out", 32'(a_out), 32'd1);

    // en=0 mid-SEND: word finishes, no new grants.
    en       = 1'b0;
    ch_valid = 8'h01;
    a_ready  = 1'b0;
    tick();
    chk("en0_hold", 32'(a_valid), 32'd1);
    a_ready = 1'b1;
    tick();
    chk("en0_done", 32'(a_valid), 32'd0);
    tick();
    chk("en0_idle", 32'(a_valid), 32'd0);
    en = 1'b1;
    tick();
    chk("en1_sel0", 32'(sel), 32'd0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      ch_valid = 8'($urandom);
      ch_data  = (8*DW)'($urandom);
      a_ready  = ($urandom_range(0, 3) != 0);
      en       = ($urandom_range(0, 4) != 0);
      tick();
    end

    // Drive the counter into saturation.
    ch_valid = 8'hFF;
    a_ready  = 1'b1;
    en       = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    chk("cnt_sat", 32'(sent_cnt), 32'hF);

    // Asynchronous reset while a word is in flight.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ch_ready", 32'(ch_ready), 32'd0);
    chk("mrst_a_valid", 32'(a_valid), 32'd0);
    chk("mrst_sel", 32'(sel), 32'd0);
    chk("mrst_a_out", 32'(a_out), 32'd0);
    chk("mrst_cnt", 32'(sent_cnt), 32'd0);
    sb_q.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    m_cnt   = 0;
    rst_n   = 1'b1;
    tick();
    chk("mrst_restart_sel", 32'(sel), 32'd0);
    tick();
    chk("mrst_restart_sel1", 32'(sel), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
